perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_pkg.sv | 26 ++
 rtl/perf_channel.sv | 82 ++++++++
 rtl/perf_counter_bank.sv | 54 +++++
 tb/tb_perf_counter_bank.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared constants and channel naming for the performance counter bank.
package perf_pkg;

  localparam int unsigned NUM_CH_DEF = 16;
  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned MAX_CH     = 32;
  localparam int unsigned CH_IDX_W   = 5;

  typedef enum logic [CH_IDX_W-1:0] {
    CH_L1I_HIT    = 5'd0,
    CH_L1I_MISS   = 5'd1,
    CH_L1D_HIT    = 5'd2,
    CH_L1D_MISS   = 5'd3,
    CH_L2_HIT     = 5'd4,
    CH_L2_MISS    = 5'd5,
    CH_BRANCH     = 5'd6,
    CH_MISPREDICT = 5'd7,
    CH_STALL      = 5'd8
  } perf_ch_e;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_channel.sv
// One event channel: edge/level qualifier, live counter, shadow copy, sticky overflow.
// Define PERF_SATURATE_EN to hold the counter at all-ones instead of wrapping.
module perf_channel
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             event_i,
  input  logic             edge_mode_i,
  input  logic             freeze_i,
  input  logic             clear_i,
  input  logic             snapshot_i,
  output logic [CNT_W-1:0] live_o,
  output logic [CNT_W-1:0] shadow_o,
  output logic             overflow_o
);

  logic             r_prev;
  logic [CNT_W-1:0] r_live;
  logic [CNT_W-1:0] r_shadow;
  logic             r_ovf;

  logic             w_qual;
  logic             w_inc;
  logic             w_at_max;
  logic [CNT_W-1:0] w_live_nxt;

  // In edge mode an event only qualifies when the previous cycle was low.
  assign w_qual   = event_i & ~(edge_mode_i & r_prev);
  assign w_inc    = w_qual & ~freeze_i & ~clear_i;
  assign w_at_max = &r_live;

`ifdef PERF_SATURATE_EN
  assign w_live_nxt = w_at_max ? r_live : r_live + CNT_W'(1);
`else
  assign w_live_nxt = r_live + CNT_W'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= event_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= '0;
    end else if (clear_i) begin
      r_live <= '0;
    end else if (w_inc) begin
      r_live <= w_live_nxt;
    end
  end

  // Shadow captures the pre-update live value; clear and freeze leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (snapshot_i) begin
      r_shadow <= r_live;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (clear_i) begin
      r_ovf <= 1'b0;
    end else if (w_inc && w_at_max) begin
      r_ovf <= 1'b1;
    end
  end

  assign live_o     = r_live;
  assign shadow_o   = r_shadow;
  assign overflow_o = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH independent event counters with shadow snapshot and a combinational read port.
// Build option: PERF_SATURATE_EN (saturating counters instead of wrapping).
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             event_i,
  input  logic [NUM_CH-1:0]             edge_mode_i,
  input  logic                          freeze_i,
  input  logic                          clear_i,
  input  logic                          snapshot_i,
  input  logic [sel_width(NUM_CH)-1:0]  read_sel_i,
  input  logic                          read_shadow_i,
  output logic [CNT_W-1:0]              read_data_o,
  output logic [NUM_CH-1:0]             overflow_o
);

  localparam int unsigned SEL_W = sel_width(NUM_CH);

  logic [CNT_W-1:0] w_live   [NUM_CH];
  logic [CNT_W-1:0] w_shadow [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .event_i     (event_i[g]),
      .edge_mode_i (edge_mode_i[g]),
      .freeze_i    (freeze_i),
      .clear_i     (clear_i),
      .snapshot_i  (snapshot_i),
      .live_o      (w_live[g]),
      .shadow_o    (w_shadow[g]),
      .overflow_o  (overflow_o[g])
    );
  end

  // Selects beyond the last channel match nothing and read as zero.
  always_comb begin
    read_data_o = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (read_sel_i == SEL_W'(c)) begin
        read_data_o = read_shadow_i ? w_shadow[c] : w_live[c];
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank (12 channels, 8-bit counters) with a behavioural model.
module tb_perf_counter_bank;

  localparam int unsigned NUM_CH  = 12;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SEL_W   = 4;
  localparam int          CNT_MAX = 255;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] event_i;
  logic [NUM_CH-1:0] edge_mode_i;
  logic              freeze_i;
  logic              clear_i;
  logic              snapshot_i;
  logic [SEL_W-1:0]  read_sel_i;
  logic              read_shadow_i;
  logic [CNT_W-1:0]  read_data_o;
  logic [NUM_CH-1:0] overflow_o;

  int n_err = 0;
  int n_chk = 0;

  int m_live   [NUM_CH];
  int m_shadow [NUM_CH];
  bit m_prev   [NUM_CH];
  bit m_ovf    [NUM_CH];

  perf_counter_bank #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .event_i       (event_i),
    .edge_mode_i   (edge_mode_i),
    .freeze_i      (freeze_i),
    .clear_i       (clear_i),
    .snapshot_i    (snapshot_i),
    .read_sel_i    (read_sel_i),
    .read_shadow_i (read_shadow_i),
    .read_data_o   (read_data_o),
    .overflow_o    (overflow_o)
  );

  always #20 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_live[c] = 0; m_shadow[c] = 0; m_prev[c] = 0; m_ovf[c] = 0;
    end
  endtask

  // Apply one clock's worth of the counting rules to the model.
  task automatic model_step();
    int old;
    for (int c = 0; c < NUM_CH; c++) begin
      old = m_live[c];
      if (snapshot_i) m_shadow[c] = old;
      if (clear_i) begin
        m_live[c] = 0;
        m_ovf[c]  = 0;
      end else if (!freeze_i && event_i[c] && !(edge_mode_i[c] && m_prev[c])) begin
        if (old == CNT_MAX) begin
          m_ovf[c] = 1;
`ifdef PERF_SATURATE_EN
          m_live[c] = CNT_MAX;
`else
          m_live[c] = 0;
`endif
        end else begin
          m_live[c] = old + 1;
        end
      end
      m_prev[c] = event_i[c];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; event_i = '0; edge_mode_i = '0; freeze_i = 0; clear_i = 0;
    snapshot_i = 0; read_sel_i = '0; read_shadow_i = 0;
    model_reset();
    #5;
    for (int s = 0; s < 16; s++) begin
      for (int m = 0; m < 2; m++) begin
        read_sel_i = SEL_W'(s); read_shadow_i = m[0];
        #1; n_chk++;
        if (read_data_o !== '0) begin
          n_err++; $display("FAIL reset_read sel=%0d sh=%0d: got %0d expected 0", s, m, read_data_o);
        end
      end
    end
    n_chk++;
    if (overflow_o !== '0) begin
      n_err++; $display("FAIL reset_ovf: got %h expected 0", overflow_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_level();
    do_clear();
    event_i[0] = 1'b1;
    repeat (5) tick();
    event_i = '0;
    read_sel_i = 4'd0; read_shadow_i = 0; #1; n_chk++;
    if (read_data_o !== 8'd5) begin
      n_err++; $display("FAIL level_ch0: got %0d expected 5", read_data_o);
    end
  endtask

  task automatic test_edge();
    int pat [6] = '{1, 1, 1, 0, 1, 1};
    edge_mode_i = '0; edge_mode_i[1] = 1'b1; event_i = '0;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      event_i[1] = pat[i][0];
      tick();
    end
    event_i = '0;
    read_sel_i = 4'd1; read_shadow_i = 0; #1; n_chk++;
    if (read_data_o !== 8'd2) begin
      n_err++; $display("FAIL edge_ch1: got %0d expected 2", read_data_o);
    end
    do_clear();
    // edge for the first two cycles, then level: counts cycles 0,2,4,5
    for (int i = 0; i < 6; i++) begin
      edge_mode_i[1] = (i < 2);
      event_i[1] = pat[i][0];
      tick();
    end
    event_i = '0; edge_mode_i = '0;
    read_sel_i = 4'd1; #1; n_chk++;
    if (read_data_o !== 8'd4) begin
      n_err++; $display("FAIL edge_to_level_ch1: got %0d expected 4", read_data_o);
    end
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] exp_val;
`ifdef PERF_SATURATE_EN
    exp_val = 8'd255;
`else
    exp_val = 8'd1;
`endif
    do_clear();
    event_i[2] = 1'b1;
    repeat (257) tick();
    event_i = '0;
    read_sel_i = 4'd2; read_shadow_i = 0; #1; n_chk++;
    if (read_data_o !== exp_val) begin
      n_err++; $display("FAIL wrap_ch2: got %0d expected %0d", read_data_o, exp_val);
    end
    n_chk++;
    if (overflow_o !== 12'h004) begin
      n_err++; $display("FAIL wrap_ovf: got %h expected 004", overflow_o);
    end
  endtask

  task automatic test_snap_clear();
    event_i = '0; event_i[3] = 1'b1;
    repeat (10) tick();
    read_sel_i = 4'd3; read_shadow_i = 0; #1; n_chk++;
    if (read_data_o !== 8'd10) begin
      n_err++; $display("FAIL snap_pre_live: got %0d expected 10", read_data_o);
    end
    snapshot_i = 1; clear_i = 1;
    tick();
    snapshot_i = 0; clear_i = 0; event_i = '0;
    read_shadow_i = 1; #1; n_chk++;
    if (read_data_o !== 8'd10) begin
      n_err++; $display("FAIL snap_shadow: got %0d expected 10", read_data_o);
    end
    read_shadow_i = 0; #1; n_chk++;
    if (read_data_o !== 8'd0) begin
      n_err++; $display("FAIL snap_live_cleared: got %0d expected 0", read_data_o);
    end
    n_chk++;
    if (overflow_o !== '0) begin
      n_err++; $display("FAIL snap_ovf_cleared: got %h expected 0", overflow_o);
    end
  endtask

  task automatic test_freeze();
    edge_mode_i = '0; event_i = '1;
    tick();
    freeze_i = 1;
    repeat (3) tick();
    edge_mode_i = '1;
    tick();
    freeze_i = 0;
    tick();
    for (int c = 0; c < NUM_CH; c++) begin
      read_sel_i = SEL_W'(c); read_shadow_i = 0; #1; n_chk++;
      if (read_data_o !== 8'd1) begin
        n_err++; $display("FAIL freeze_live ch=%0d: got %0d expected 1", c, read_data_o);
      end
    end
    read_sel_i = 4'd3; read_shadow_i = 1; #1; n_chk++;
    if (read_data_o !== 8'd10) begin
      n_err++; $display("FAIL freeze_shadow_ch3: got %0d expected 10", read_data_o);
    end
    event_i = '0; tick();
    event_i = '1; tick();
    event_i = '0; edge_mode_i = '0;
    read_sel_i = 4'd0; read_shadow_i = 0; #1; n_chk++;
    if (read_data_o !== 8'd2) begin
      n_err++; $display("FAIL freeze_after_edge_ch0: got %0d expected 2", read_data_o);
    end
  endtask

  task automatic test_range();
    for (int s = NUM_CH; s < 16; s++) begin
      for (int m = 0; m < 2; m++) begin
        read_sel_i = SEL_W'(s); read_shadow_i = m[0]; #1; n_chk++;
        if (read_data_o !== '0) begin
          n_err++; $display("FAIL range sel=%0d sh=%0d: got %0d expected 0", s, m, read_data_o);
        end
      end
    end
  endtask

  task automatic test_random();
    int c;
    logic [NUM_CH-1:0] exp_ovf;
    for (int i = 0; i < 600; i++) begin
      event_i     = NUM_CH'($urandom) | NUM_CH'($urandom);
      edge_mode_i = NUM_CH'($urandom);
      freeze_i    = ($urandom_range(0, 15) == 0);
      clear_i     = ($urandom_range(0, 199) == 0);
      snapshot_i  = ($urandom_range(0, 7) == 0);
      tick();
      c = $urandom_range(0, NUM_CH - 1);
      read_sel_i = SEL_W'(c); read_shadow_i = 0; #1; n_chk++;
      if (read_data_o !== CNT_W'(m_live[c])) begin
        n_err++; $display("FAIL rand_live cyc=%0d ch=%0d: got %0d expected %0d", i, c, read_data_o, m_live[c]);
      end
      read_shadow_i = 1; #1; n_chk++;
      if (read_data_o !== CNT_W'(m_shadow[c])) begin
        n_err++; $display("FAIL rand_shadow cyc=%0d ch=%0d: got %0d expected %0d", i, c, read_data_o, m_shadow[c]);
      end
      for (int k = 0; k < NUM_CH; k++) exp_ovf[k] = m_ovf[k];
      n_chk++;
      if (overflow_o !== exp_ovf) begin
        n_err++; $display("FAIL rand_ovf cyc=%0d: got %h expected %h", i, overflow_o, exp_ovf);
      end
    end
    event_i = '0; edge_mode_i = '0; freeze_i = 0; clear_i = 0; snapshot_i = 0;
  endtask

  task automatic test_async_reset();
    event_i = '1;
    tick();
    snapshot_i = 1; clear_i = 1;
    #7;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int m = 0; m < 2; m++) begin
        read_sel_i = SEL_W'(c); read_shadow_i = m[0]; #1; n_chk++;
        if (read_data_o !== '0) begin
          n_err++; $display("FAIL async_reset ch=%0d sh=%0d: got %0d expected 0", c, m, read_data_o);
        end
      end
    end
    n_chk++;
    if (overflow_o !== '0) begin
      n_err++; $display("FAIL async_reset_ovf: got %h expected 0", overflow_o);
    end
    @(posedge clk); #1;
    snapshot_i = 0; clear_i = 0; event_i = '0;
    rst_n = 1'b1;
    event_i[0] = 1'b1;
    tick();
    event_i = '0;
    read_sel_i = 4'd0; read_shadow_i = 0; #1; n_chk++;
    if (read_data_o !== 8'd1) begin
      n_err++; $display("FAIL post_reset_count: got %0d expected 1", read_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_wrap();
    test_snap_clear();
    test_freeze();
    test_range();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
